adc_scan_sequencer: RTL
=======================

// Module: adc_scan_sequencer
// PURPOSE
//  Drives the TLC1543 serial-ADC controller (start_sig/channel) and consumes its data/data_valid.
//  Round-robin scans the enabled channels of a 14-bit mask and averages 2^AVG_LOG2 samples per channel.
//  Stores per-channel results in a register bank and emits one result strobe per stored channel.
//  Sits between the ADC controller and the AXI register / capture logic.
// PARAMETERS
//  AVG_LOG2        2        log2 of samples averaged per channel (0..4; 0 = no averaging)
//  TIMEOUT_CYCLES  100_000  clk_in cycles to wait for data_valid before abandoning a conversion
// PORTS
//  clk_in       in   1   system clock
//  reset_n      in   1   asynchronous active-low reset
//  enable       in   1   level; 1 = scan continuously
//  chan_mask    in   14  bit k enables ADC channel k (0..10 analog, 11..13 internal refs)
//  start_sig    out  1   conversion request to the ADC controller
//  channel      out  4   channel number for the current request
//  adc_data     in   10  conversion result from the controller
//  adc_valid    in   1   controller data-valid level (high for several cycles per result)
//  res_valid    out  1   1-cycle strobe: averaged result stored
//  res_channel  out  4   channel of res_data
//  res_data     out  10  averaged result
//  scan_done    out  1   1-cycle strobe after the last enabled channel of a pass is stored
//  valid_mask   out  14  bit k set once channel k has held a result since reset
//  timeout_err  out  1   sticky; set on adc_valid timeout; cleared by reset or enable=0
//  rd_chan      in   4   register-bank read index
//  rd_data      out  10  combinational bank[rd_chan]; 0 when rd_chan > 13
// BEHAVIOUR
//  Reset: all outputs 0; bank, accumulator and sample count 0; state IDLE.
//  States:
//   IDLE   -> PICK when enable=1 and chan_mask!=0. Mask latched into scan_mask on this edge.
//   PICK   finds the next set bit of scan_mask above cur_ch, wrapping to the lowest set bit.
//          Wrap (or first pick) re-latches chan_mask; re-latched mask==0 -> IDLE.
//          Takes 1 cycle -> ISSUE.
//   ISSUE  start_sig=1, channel=cur_ch (stable until start_sig drops) -> WAIT.
//   WAIT   start_sig held 1 until the adc_valid rising edge.
//          On that edge: sample adc_data, start_sig=0, acc += adc_data, n += 1 -> GAP.
//          If TIMEOUT_CYCLES elapse first: start_sig=0, timeout_err=1,
//          acc/n cleared, channel skipped -> GAP.
//   GAP    waits adc_valid=0.
//          n == 2^AVG_LOG2 -> STORE; otherwise re-ISSUE the same channel.
//          enable=0 -> IDLE (partial accumulator discarded).
//   STORE  1 cycle: bank[cur_ch] = acc >> AVG_LOG2 (truncate); valid_mask[cur_ch]=1;
//          res_valid pulse with res_channel/res_data; acc,n cleared.
//          If cur_ch is the highest set bit of scan_mask, scan_done pulses in the same cycle.
//          Then -> PICK (-> IDLE if enable=0).
//  Widths: acc is 10+AVG_LOG2 bits; no overflow possible (max 1023 * 16).
//  The adc_valid rising edge is detected on a registered copy; only one sample per edge.
//  A valid edge outside WAIT is ignored.
//  enable=0 in ISSUE/WAIT: the in-flight conversion completes or times out, is discarded,
//  then -> IDLE; timeout_err clears while enable=0.
//  Single-channel mask: same channel is issued repeatedly, with scan_done on every store.
//  Latency: one STORE per 2^AVG_LOG2 controller transactions + 1 PICK cycle + 1 ISSUE cycle.
//  Async reset mid-conversion: start_sig drops immediately; the controller finishes its
//  transaction unaided.
// STRUCTURE
//  Shared package tlc1543_pkg: NUM_CH=14, CH_W=4, DATA_W=10, scan-state enum, helper
//  function next_set_bit(mask, cur).
//  Sub-module: existing edgedetect instance on adc_valid.
//  Everything else (FSM, timeout counter, accumulator, 14x10 bank) is inline.
// TESTING
//  1. mask=14'h0005, AVG_LOG2=0, model returns 100+ch:
//     order 0,2,0,2; res_data 100,102; scan_done after ch2; valid_mask=0005.
//  2. AVG_LOG2=2, ch3 samples 10,11,12,13 -> one res_valid, res_data=11, bank[3]=11.
//  3. Model never raises adc_valid, TIMEOUT_CYCLES=50:
//     start_sig drops at cycle 51, timeout_err=1, next channel issued.
//     enable=0 clears timeout_err.
//  4. Change mask 0001->0010 mid-scan: the current pass completes on the old mask,
//     the next pass uses ch4 only. mask=0 -> no start_sig.
//  5. Deassert enable during WAIT: conversion finishes, no res_valid, state IDLE.
//     Reset pulse in WAIT: all outputs 0 within the reset cycle.
//  6. adc_data=1023 for 16 samples, AVG_LOG2=4 -> res_data=1023 (no overflow).
//     rd_chan=15 -> rd_data=0.

Source files
------------

// File: rtl/tlc1543_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tlc1543_pkg
//  Brief    : Shared widths, scan-state encoding and channel-pick helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package tlc1543_pkg;

    localparam int NUM_CH = 14;
    localparam int CH_W   = 4;
    localparam int DATA_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PICK  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_STORE = 3'd5
    } scan_state_t;

    typedef struct packed {
        logic            wrap;
        logic [CH_W-1:0] idx;
    } pick_t;

    // Next set bit above cur; wrap=1 means nothing above, idx is then the lowest set bit.
    function automatic pick_t next_set_bit(input logic [NUM_CH-1:0] mask,
                                           input logic [CH_W-1:0]   cur);
        pick_t res;
        res.wrap = 1'b1;
        res.idx  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask[k] && (k > int'(cur))) begin
                res.idx  = CH_W'(k);
                res.wrap = 1'b0;
            end
        end
        if (res.wrap) begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (mask[k]) begin
                    res.idx = CH_W'(k);
                end
            end
        end
        return res;
    endfunction

    function automatic logic [CH_W-1:0] lowest_set_bit(input logic [NUM_CH-1:0] mask);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask[k]) begin
                idx = CH_W'(k);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edgedetect.sv
`default_nettype none
// ============================================================================
//  Module   : edgedetect
//  Brief    : Rising-edge detector against a registered copy of the input.
//  Revision : 1.0 - initial release
// ============================================================================
module edgedetect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic r_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d <= 1'b0;
        end else begin
            r_d <= d;
        end
    end

    assign rise = d & ~r_d;

endmodule
`default_nettype wire

// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : adc_scan_sequencer
//  Brief    : Round-robin TLC1543 channel scanner with per-channel averaging
//             and a 14x10 result bank.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_scan_sequencer
    import tlc1543_pkg::*;
#(
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [NUM_CH-1:0] chan_mask,
    output logic              start_sig,
    output logic [CH_W-1:0]   channel,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    output logic              res_valid,
    output logic [CH_W-1:0]   res_channel,
    output logic [DATA_W-1:0] res_data,
    output logic              scan_done,
    output logic [NUM_CH-1:0] valid_mask,
    output logic              timeout_err,
    input  logic [CH_W-1:0]   rd_chan,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned c_ACC_W = DATA_W + AVG_LOG2;
    localparam int unsigned c_CNT_W = AVG_LOG2 + 1;
    localparam int unsigned c_TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_NUM_SAMPLES = c_CNT_W'(1 << AVG_LOG2);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST    = c_TMR_W'(TIMEOUT_CYCLES - 1);

    scan_state_t         r_state;
    logic [NUM_CH-1:0]   r_scan_mask;
    logic [CH_W-1:0]     r_cur_ch;
    logic [c_ACC_W-1:0]  r_acc;
    logic [c_CNT_W-1:0]  r_n;
    logic [c_TMR_W-1:0]  r_timer;
    logic                r_first;
    logic                r_skip;
    logic [DATA_W-1:0]   r_bank [NUM_CH];

    logic                w_valid_rise;
    pick_t               w_next;
    logic [CH_W-1:0]     w_lowest;
    logic [DATA_W-1:0]   w_avg;

    edgedetect u_valid_edge (
        .clk   (clk_in),
        .rst_n (reset_n),
        .d     (adc_valid),
        .rise  (w_valid_rise)
    );

    assign w_next   = next_set_bit(r_scan_mask, r_cur_ch);
    assign w_lowest = lowest_set_bit(chan_mask);
    assign w_avg    = DATA_W'(r_acc >> AVG_LOG2);

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_chan == CH_W'(k)) begin
                rd_data = r_bank[k];
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_scan_mask <= '0;
            r_cur_ch    <= '0;
            r_acc       <= '0;
            r_n         <= '0;
            r_timer     <= '0;
            r_first     <= 1'b0;
            r_skip      <= 1'b0;
            start_sig   <= 1'b0;
            channel     <= '0;
            res_valid   <= 1'b0;
            res_channel <= '0;
            res_data    <= '0;
            scan_done   <= 1'b0;
            valid_mask  <= '0;
            timeout_err <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_bank[k] <= '0;
            end
        end else begin
            res_valid <= 1'b0;
            scan_done <= 1'b0;
            if (!enable) begin
                timeout_err <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_acc  <= '0;
                    r_n    <= '0;
                    r_skip <= 1'b0;
                    if (enable && (chan_mask != '0)) begin
                        r_scan_mask <= chan_mask;
                        r_first     <= 1'b1;
                        r_state     <= ST_PICK;
                    end
                end

                // A new pass (first pick or wrap) picks up the live mask.
                ST_PICK: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (r_first || w_next.wrap) begin
                        r_first     <= 1'b0;
                        r_scan_mask <= chan_mask;
                        if (chan_mask == '0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cur_ch  <= w_lowest;
                            channel   <= w_lowest;
                            start_sig <= 1'b1;
                            r_state   <= ST_ISSUE;
                        end
                    end else begin
                        r_cur_ch  <= w_next.idx;
                        channel   <= w_next.idx;
                        start_sig <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (w_valid_rise) begin
                        start_sig <= 1'b0;
                        r_acc     <= r_acc + c_ACC_W'(adc_data);
                        r_n       <= r_n + 1'b1;
                        r_state   <= ST_GAP;
                    end else if (r_timer == c_TMR_LAST) begin
                        start_sig <= 1'b0;
                        if (enable) begin
                            timeout_err <= 1'b1;
                        end
                        r_acc   <= '0;
                        r_n     <= '0;
                        r_skip  <= 1'b1;
                        r_state <= ST_GAP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (!adc_valid) begin
                        if (!enable) begin
                            r_state <= ST_IDLE;
                        end else if (r_skip) begin
                            r_skip  <= 1'b0;
                            r_state <= ST_PICK;
                        end else if (r_n == c_NUM_SAMPLES) begin
                            r_state <= ST_STORE;
                        end else begin
                            start_sig <= 1'b1;
                            r_state   <= ST_ISSUE;
                        end
                    end
                end

                ST_STORE: begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (r_cur_ch == CH_W'(k)) begin
                            r_bank[k]     <= w_avg;
                            valid_mask[k] <= 1'b1;
                        end
                    end
                    res_valid   <= 1'b1;
                    res_channel <= r_cur_ch;
                    res_data    <= w_avg;
                    scan_done   <= w_next.wrap;
                    r_acc       <= '0;
                    r_n         <= '0;
                    r_state     <= enable ? ST_PICK : ST_IDLE;
                end

                default: begin
                    start_sig <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
